multiplicador_algoritmico: RTL

Iterative signed shift-and-add multiplier with a single-cycle Start/Done handshake; companion to the team's iterative divider, sharing its port style and latency class. Operands are converted to magnitude, multiplied one bit per iteration, and the product's sign is corrected in a final cycle. It sits in the datapath as a multi-cycle arithmetic unit that a controller launches with Start and polls via Busy/Done.

---
 rtl/multiplicador_algoritmico.sv | 127 ++++++++++++
 1 files changed

// File: rtl/multiplicador_algoritmico.sv
// Iterative signed shift-and-add multiplier, Start/Done handshake, 2*tamanyo+1 cycles.
// Define MULT_CHECK_EN to compile in the protocol and result assertions.
module multiplicador_algoritmico #(
    parameter int tamanyo = 32
) (
    input  logic                   CLK,
    input  logic                   RSTa,
    input  logic                   Start,
    input  logic [tamanyo-1:0]     A,
    input  logic [tamanyo-1:0]     B,
    output logic [2*tamanyo-1:0]   Prod,
    output logic                   Busy,
    output logic                   Done
);

    localparam int CW = $clog2(tamanyo);

    typedef enum logic [1:0] {IDLE, ADD, SHIFT, FIX} estado_t;

    estado_t state, next;

    logic [tamanyo:0]     acc;
    logic [tamanyo-1:0]   q;
    logic [tamanyo-1:0]   m;
    logic [CW-1:0]        cont;
    logic                 sa;
    logic                 sb;
    logic [2*tamanyo-1:0] p;

    // Most negative input maps to 2^(tamanyo-1), which fits unsigned.
    function automatic logic [tamanyo-1:0] magnitud(input logic [tamanyo-1:0] x);
        return x[tamanyo-1] ? (~x + 1'b1) : x;
    endfunction

    assign p = {acc[tamanyo-1:0], q};

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa)
            state <= IDLE;
        else
            state <= next;
    end

    always_comb begin
        next = state;
        Busy = 1'b0;
        unique case (state)
            IDLE:    if (Start) next = ADD;
            ADD: begin
                Busy = 1'b1;
                next = SHIFT;
            end
            SHIFT: begin
                Busy = 1'b1;
                next = (cont == '0) ? FIX : ADD;
            end
            FIX: begin
                Busy = 1'b1;
                next = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            acc  <= '0;
            q    <= '0;
            m    <= '0;
            cont <= '0;
            sa   <= 1'b0;
            sb   <= 1'b0;
            Prod <= '0;
            Done <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        sa   <= A[tamanyo-1];
                        sb   <= B[tamanyo-1];
                        m    <= magnitud(A);
                        q    <= magnitud(B);
                        acc  <= '0;
                        cont <= CW'(tamanyo - 1);
                    end
                end
                ADD: begin
                    if (q[0])
                        acc <= acc + {1'b0, m};
                end
                SHIFT: begin
                    {acc, q} <= {acc, q} >> 1;
                    cont     <= cont - 1'b1;
                end
                FIX: begin
                    Prod <= (sa ^ sb) ? (~p + 1'b1) : p;
                    Done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef MULT_CHECK_EN
    a_start_busy: assert property (
        @(posedge CLK) disable iff (!RSTa) Start |-> !Busy
    ) else $error("Multiplicacion en curso");

    a_done_pulse: assert property (
        @(posedge CLK) disable iff (!RSTa) Done |=> !Done
    ) else $error("Done activo dos ciclos seguidos");

    // Done is first sampled one edge after FIX, so the Start-cycle operands sit 2T+2 edges back.
    a_producto: assert property (
        @(posedge CLK) disable iff (!RSTa)
        $rose(Done) |-> $signed(Prod) ==
            $signed($past(A, 2*tamanyo+2)) * $signed($past(B, 2*tamanyo+2))
    ) else $error("Producto incorrecto");

    a_init: assert property (
        @(posedge CLK) disable iff (!RSTa)
        (state == ADD && $past(state) == IDLE) |-> (acc == '0 && cont == CW'(tamanyo - 1))
    ) else $error("Inicializacion incorrecta");
`endif

endmodule
